// File: rtl/turn_signal_input_stage.sv
// -----------------------------------------------------------------------------
// turn_signal_input_stage
//
// Front end of the turn-signal datapath. Each raw active-low button is
// synchronized, then debounced. The debounced set is priority-encoded into a
// single legal stimulus code. A divider produces the enable step clock.
//
// Ports:
//   clock        in   single clock, all state on its rising edge
//   reset        in   asynchronous, active-low reset
//   buttons[3:0] in   raw active-low buttons {LEFT, HAZARD, RESET, RIGHT}
//   stimulus[3:0]out  registered active-low code, at most one bit low
//   enable       out  registered square wave, sequencer steps on its fall
//   any_pressed  out  registered, high while any debounced button is pressed
// -----------------------------------------------------------------------------
module turn_signal_input_stage #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HALF_PERIOD     = 8,
  parameter int DB_W            = 5,
  parameter int DIV_W           = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons,
  output logic [3:0] stimulus,
  output logic       enable,
  output logic       any_pressed
);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  // Divider states; the encoding equals the enable level it drives.
  localparam logic [0:0] IDLE_LOW  = 1'b0;
  localparam logic [0:0] IDLE_HIGH = 1'b1;

  localparam logic [3:0] STIM_LEFT   = 4'b0111;
  localparam logic [3:0] STIM_HAZARD = 4'b1011;
  localparam logic [3:0] STIM_RESET  = 4'b1101;
  localparam logic [3:0] STIM_RIGHT  = 4'b1110;
  localparam logic [3:0] STIM_IDLE   = 4'b1111;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'b1111;
      sync_q  <= 4'b1111;
    end else begin
      sync1_q <= buttons;
      sync_q  <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce: a change is accepted only after it has been seen on
  // DEBOUNCE_CYCLES consecutive edges; any return to the stable level clears
  // the count.
  // ---------------------------------------------------------------------------
  logic [3:0] stable;

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[gi] != stable_q) begin
        if (cnt_q == DB_LAST) begin
          stable_d = sync_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        stable_q <= 1'b1;
        cnt_q    <= '0;
      end else begin
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign stable[gi] = stable_q;
  end

  // ---------------------------------------------------------------------------
  // Priority encode: RESET > HAZARD > LEFT > RIGHT
  // ---------------------------------------------------------------------------
  logic [3:0] stimulus_q;
  logic [3:0] stimulus_d;
  logic       any_pressed_q;

  always_comb begin
    if (!stable[1])      stimulus_d = STIM_RESET;
    else if (!stable[2]) stimulus_d = STIM_HAZARD;
    else if (!stable[3]) stimulus_d = STIM_LEFT;
    else if (!stable[0]) stimulus_d = STIM_RIGHT;
    else                 stimulus_d = STIM_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stimulus_q    <= STIM_IDLE;
      any_pressed_q <= 1'b0;
    end else begin
      stimulus_q    <= stimulus_d;
      any_pressed_q <= ~&stable;
    end
  end

  // ---------------------------------------------------------------------------
  // Enable divider. A stimulus change re-phases it so the first sequencer
  // step lands exactly HALF_PERIOD edges after the change; the re-phase wins
  // over a terminal-count toggle on the same edge.
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             rephase;

  assign rephase = (stimulus_d != stimulus_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    if (rephase) begin
      state_d = IDLE_HIGH;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      state_d = (state_q == IDLE_HIGH) ? IDLE_LOW : IDLE_HIGH;
      div_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_HIGH;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  assign stimulus    = stimulus_q;
  assign any_pressed = any_pressed_q;
  assign enable      = (state_q == IDLE_HIGH);

endmodule
